// File: rtl/booth_iter_mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
// Holds the operation encodings, the FSM state encodings and the Booth digit
// count helper. Imported by booth_iter_mul and booth_decode.
package booth_iter_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,  // low half of product
    OP_MULH   = 2'd1,  // high half, signed x signed
    OP_MULHSU = 2'd2,  // high half, signed x unsigned
    OP_MULHU  = 2'd3   // high half, unsigned x unsigned
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int unsigned XLEN_DEF = 64;

  // Number of radix-4 digits needed to cover an operand extended to xlen+2 bits.
  function automatic int unsigned ndig(input int unsigned xlen);
    return (xlen + 2) / 2;
  endfunction

  localparam int unsigned NDIG_DEF = ndig(XLEN_DEF);

endpackage

// File: rtl/booth_decode.sv
// Booth digit to partial product selection (purely combinational).
// Ports:
//   zero   - digit is 0, partial product and carry-in forced to 0
//   invert - digit is negative, partial product is ones-complement
//   dbl    - digit magnitude is 2, multiplicand shifted left by one
//   mcand  - extended multiplicand (W bits)
//   pp     - selected partial product (W bits, two's complement)
//   cin    - carry-in completing the negation of an inverted product
module booth_decode
  import booth_iter_mul_pkg::*;
#(
  parameter int unsigned W = 66
) (
  input  logic         zero,
  input  logic         invert,
  input  logic         dbl,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] pp,
  output logic         cin
);

  logic [W-1:0] mag;

  always_comb begin
    mag = dbl ? {mcand[W-2:0], 1'b0} : mcand;
    pp  = '0;
    cin = 1'b0;
    if (!zero) begin
      pp  = invert ? ~mag : mag;
      cin = invert;
    end
  end

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier, one digit per cycle.
// Optional build macro: MUL_EARLY_OUT_EN ends the iteration as soon as the
// remaining multiplier digits are all zero (result values unchanged).
// Ports:
//   clk_i, rst_n_i      - clock, asynchronous active-low reset
//   valid_i / ready_o   - request handshake (ready_o only in IDLE)
//   op_i, rs1_i, rs2_i  - operation select, multiplicand, multiplier
//   flush_i             - abort; forces IDLE next cycle, result discarded
//   valid_o / ready_i   - result handshake
//   result_o            - selected product half, stable while valid_o
module booth_iter_mul
  import booth_iter_mul_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned NDIG = ndig(XLEN);
  localparam int unsigned EW   = XLEN + 2;
  localparam int unsigned AW   = 2 * XLEN;
  localparam int unsigned IW   = $clog2(NDIG + 1);

  mul_state_e      state_q;
  mul_op_e         op_q;
  logic [EW-1:0]   mcand_q;
  // Multiplier with m[-1] appended at bit 0; shifted right two bits per
  // digit so the current group always sits in [2:0].
  logic [EW:0]     mult_q;
  logic [AW-1:0]   acc_q;
  logic [IW-1:0]   idx_q;
  logic            ready_q;
  logic            valid_q;
  logic [XLEN-1:0] result_q;

  logic            rs1_signed;
  logic            rs2_signed;
  logic [EW-1:0]   rs1_ext;
  logic [EW-1:0]   rs2_ext;

  always_comb begin
    rs1_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU);
    rs2_signed = (op_i == OP_MULH);
    rs1_ext    = {{2{rs1_signed & rs1_i[XLEN-1]}}, rs1_i};
    rs2_ext    = {{2{rs2_signed & rs2_i[XLEN-1]}}, rs2_i};
  end

  logic [2:0]      grp;
  logic            dig_zero;
  logic            dig_invert;
  logic            dig_dbl;
  logic [EW-1:0]   pp;
  logic            cin;

  always_comb begin
    grp        = mult_q[2:0];
    dig_zero   = (grp == 3'b000) || (grp == 3'b111);
    dig_invert = grp[2];
    dig_dbl    = (grp == 3'b011) || (grp == 3'b100);
  end

  booth_decode #(
    .W (EW)
  ) u_booth_decode (
    .zero   (dig_zero),
    .invert (dig_invert),
    .dbl    (dig_dbl),
    .mcand  (mcand_q),
    .pp     (pp),
    .cin    (cin)
  );

  logic [AW-1:0]   addend;
  logic [AW-1:0]   acc_nxt;
  logic            last_dig;
  logic [XLEN-1:0] result_sel;

  always_comb begin
    // Adding cin before the shift places the carry-in exactly at bit 2i.
    addend  = ({{(AW-EW){pp[EW-1]}}, pp} + AW'(cin)) << {idx_q, 1'b0};
    acc_nxt = acc_q + addend;
`ifdef MUL_EARLY_OUT_EN
    // mult_q[EW:2] holds the current top bit and every unprocessed bit
    // (sign-filled); uniform means all remaining digits are zero.
    last_dig = (&mult_q[EW:2]) || (~|mult_q[EW:2]) || (idx_q == IW'(NDIG - 1));
`else
    last_dig = (idx_q == IW'(NDIG - 1));
`endif
    result_sel = (op_q == OP_MUL) ? acc_nxt[XLEN-1:0] : acc_nxt[AW-1:XLEN];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mult_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mult_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            state_q <= ST_BUSY;
            op_q    <= mul_op_e'(op_i);
            mcand_q <= rs1_ext;
            mult_q  <= {rs2_ext, 1'b0};
            acc_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          acc_q  <= acc_nxt;
          mult_q <= {mult_q[EW], mult_q[EW], mult_q[EW:2]};
          idx_q  <= idx_q + IW'(1);
          if (last_dig) begin
            state_q  <= ST_DONE;
            valid_q  <= 1'b1;
            result_q <= result_sel;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: doc/booth_iter_mul.md
BOOTH_ITER_MUL -- requirements
Module: booth_iter_mul

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning operand/result width (even, >=8).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i  input  1  request valid.
REQ-005 SHALL have port ready_o  output  1  block can accept a request.
REQ-006 SHALL have port op_i  input  2  0=MUL (low), 1=MULH (s*s high), 2=MULHSU (s*u high), 3=MULHU (u*u high).
REQ-007 SHALL have port rs1_i  input  XLEN  multiplicand.
REQ-008 SHALL have port rs2_i  input  XLEN  multiplier, Booth-encoded internally.
REQ-009 SHALL have port flush_i  input  1  abort current operation.
REQ-010 SHALL have port valid_o  output  1  result valid.
REQ-011 SHALL have port ready_i  input  1  consumer accepts result.
REQ-012 SHALL have port result_o  output  XLEN  selected product half.

Function
- REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
- REQ-014 ready_o SHALL be 1 only in IDLE.
- REQ-015 A request SHALL be accepted when valid_i & ready_o; IDLE->BUSY; op_i, rs1_i, rs2_i captured.
- REQ-016 Operands SHALL be extended to XLEN+2 bits: sign-extended if signed for that op, else zero-extended.
- REQ-017 Multiplier SHALL be scanned as NDIG=(XLEN+2)/2 overlapping 3-bit groups {m[2i+1],m[2i],m[2i-1]}, m[-1]=0.
- REQ-018 Each BUSY cycle SHALL process one group: it derives zero/invert/double indices (000,111 zero; 1xx invert; 011,100 double) and adds the resulting partial product, shifted left by 2i, into a 2*XLEN-bit accumulator, modulo 2^(2*XLEN).
- REQ-019 Invert SHALL be realised as ones-complement plus a carry-in of 1 at bit 2i.
- REQ-020 Without early-out, BUSY SHALL last exactly NDIG cycles; BUSY->DONE after the last group.
- REQ-021 In DONE, valid_o=1; result_o = acc[XLEN-1:0] for MUL, else acc[2*XLEN-1:XLEN]; result_o SHALL hold stable until handshake.
- REQ-022 DONE->IDLE on ready_i; a new request SHALL be accepted no earlier than the following cycle.
- REQ-023 flush_i SHALL force IDLE next cycle from any state, discarding the result; valid_o=0 next cycle.
- REQ-024 flush_i asserted together with valid_i in IDLE SHALL NOT accept the request.
- REQ-025 Accumulator and operand registers SHALL be cleared on acceptance; there SHALL be no residue from aborted operations.

Reset
- REQ-026 On rst_n_i=0, the block SHALL enter IDLE asynchronously.
- REQ-027 During reset, outputs SHALL be ready_o=1, valid_o=0, result_o=0, and all internal registers SHALL be 0.
- REQ-028 Reset mid-BUSY or mid-DONE SHALL drop the operation; no result is produced.

Configuration
- REQ-029 Macro MUL_EARLY_OUT_EN, when defined, SHALL end BUSY after the cycle in which the unprocessed multiplier bits, including the current group's top bit, are all 0 or all 1 (remaining digits all zero). Result values SHALL be identical in both builds.
- REQ-030 Without MUL_EARLY_OUT_EN, latency SHALL be fixed at NDIG BUSY cycles for every operand.

Structure
- REQ-031 The op encodings, FSM state encodings and NDIG SHALL live in the shared QianTang header package.
- REQ-032 Combinational digit-to-partial-product selection SHALL be a sub-module named booth_decode. Inputs: zero, invert and double indices plus the XLEN+2-bit multiplicand. Outputs: partial product and carry-in.

Verification
- V1 MUL, XLEN=64, rs1=3, rs2=5 -> valid_o after 1+33 cycles (no early-out), result_o=15.
- V2 MULH, rs1=rs2=0x8000_0000_0000_0000 -> result_o=0x4000_0000_0000_0000; MUL same operands -> 0.
- V3 MULHSU, rs1=-1, rs2=0xFFFF_FFFF_FFFF_FFFF -> result_o=0xFFFF_FFFF_FFFF_FFFF; MULHU same operands -> 0xFFFF_FFFF_FFFF_FFFE.
- V4 flush_i in the 10th BUSY cycle, then MUL 7*6 -> no valid_o for the first request; second result_o=42.
- V5 ready_i held 0 for 5 cycles in DONE -> valid_o and result_o stable, ready_o=0; new valid_i ignored until ready_i.
- V6 With MUL_EARLY_OUT_EN, MUL rs1=9, rs2=2 -> valid_o within 3 cycles of acceptance, result_o=18; random 10k ops match the non-early-out build.
